// File: rtl/mult8_seq_ctrl.sv
// mult8_seq_ctrl: 8x8 unsigned multiply sequenced over a shared 4x4 core.
// Optional feature macro: MULT_SEQ_ZERO_SKIP_EN (zero operands bypass the core).
module mult8_seq_ctrl #(
    parameter int CORE_LAT = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  in_a,
    input  logic [7:0]  in_b,
    output logic [3:0]  core_a,
    output logic [3:0]  core_b,
    input  logic [7:0]  core_prod,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out_prod,
    output logic        busy
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_MUL,
        S_DONE
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic [7:0]  r_a;
    logic [7:0]  r_b;
    logic [15:0] r_acc;
    logic [15:0] r_prod;
    logic [1:0]  r_step;
    logic        r_lat;
    logic        w_last;
    logic [15:0] w_pp;
    logic [15:0] w_sum;

`ifdef MULT_SEQ_ZERO_SKIP_EN
    logic w_zero;
    assign w_zero = (in_a == 8'h00) || (in_b == 8'h00);
`endif

    // Core output is only trusted on the final cycle of a step.
    assign w_last = (r_lat == 1'(CORE_LAT));
    assign w_sum  = r_acc + w_pp;

    assign in_ready  = (r_state == S_IDLE);
    assign out_valid = (r_state == S_DONE);
    assign busy      = (r_state != S_IDLE);
    assign out_prod  = r_prod;

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (in_valid) begin
`ifdef MULT_SEQ_ZERO_SKIP_EN
                    w_next = w_zero ? S_DONE : S_MUL;
`else
                    w_next = S_MUL;
`endif
                end
            end
            S_MUL: begin
                if (w_last && (r_step == 2'd3)) begin
                    w_next = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    w_next = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Nibbles stay at zero outside MUL so the core does not toggle.
    always_comb begin
        core_a = 4'h0;
        core_b = 4'h0;
        w_pp   = 16'h0000;
        if (r_state == S_MUL) begin
            unique case (r_step)
                2'd0: begin
                    core_a = r_a[3:0];
                    core_b = r_b[3:0];
                    w_pp   = {8'h00, core_prod};
                end
                2'd1: begin
                    core_a = r_a[7:4];
                    core_b = r_b[3:0];
                    w_pp   = {4'h0, core_prod, 4'h0};
                end
                2'd2: begin
                    core_a = r_a[3:0];
                    core_b = r_b[7:4];
                    w_pp   = {4'h0, core_prod, 4'h0};
                end
                default: begin
                    core_a = r_a[7:4];
                    core_b = r_b[7:4];
                    w_pp   = {core_prod, 8'h00};
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_a     <= 8'h00;
            r_b     <= 8'h00;
            r_acc   <= 16'h0000;
            r_prod  <= 16'h0000;
            r_step  <= 2'd0;
            r_lat   <= 1'b0;
        end else begin
            r_state <= w_next;
            if ((r_state == S_IDLE) && in_valid) begin
                r_a    <= in_a;
                r_b    <= in_b;
                r_acc  <= 16'h0000;
                r_step <= 2'd0;
                r_lat  <= 1'b0;
`ifdef MULT_SEQ_ZERO_SKIP_EN
                if (w_zero) begin
                    r_prod <= 16'h0000;
                end
`endif
            end
            if (r_state == S_MUL) begin
                if (w_last) begin
                    r_acc  <= w_sum;
                    r_step <= r_step + 2'd1;
                    r_lat  <= 1'b0;
                    if (r_step == 2'd3) begin
                        r_prod <= w_sum;
                    end
                end else begin
                    r_lat <= r_lat + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_mult8_seq_ctrl.sv
// Scoreboard bench for mult8_seq_ctrl: a combinational-core and a
// registered-core instance share stimulus; each has its own reference model.
module tb_mult8_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic [7:0]  in_a;
    logic [7:0]  in_b;
    logic        out_ready;
    logic [1:0]  in_ready;
    logic [1:0]  out_valid;
    logic [1:0]  busy;
    logic [3:0]  core_a [2];
    logic [3:0]  core_b [2];
    logic [15:0] out_prod [2];
    logic [7:0]  cp0;
    logic [7:0]  cp1;

    int cyc = 0;
    int n_cmp = 0;
    int n_fail = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign cp0 = {4'h0, core_a[0]} * {4'h0, core_b[0]};
    always @(posedge clk) cp1 <= {4'h0, core_a[1]} * {4'h0, core_b[1]};

    mult8_seq_ctrl #(.CORE_LAT(0)) u0 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready[0]),
        .in_a(in_a), .in_b(in_b),
        .core_a(core_a[0]), .core_b(core_b[0]), .core_prod(cp0),
        .out_valid(out_valid[0]), .out_ready(out_ready),
        .out_prod(out_prod[0]), .busy(busy[0])
    );

    mult8_seq_ctrl #(.CORE_LAT(1)) u1 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready[1]),
        .in_a(in_a), .in_b(in_b),
        .core_a(core_a[1]), .core_b(core_b[1]), .core_prod(cp1),
        .out_valid(out_valid[1]), .out_ready(out_ready),
        .out_prod(out_prod[1]), .busy(busy[1])
    );

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got %0h want %0h", nm, cyc, act, exp);
        end
    endtask

    typedef struct packed {
        logic [15:0] p;
        logic [7:0]  a;
        logic [7:0]  b;
        int          e;
        int          d;
    } job_t;

    for (genvar g = 0; g < 2; g++) begin : g_mon
        localparam int L = g;
        localparam int STEPS = 4 * (1 + L);
        job_t        q[$];
        job_t        nj;
        int          hs = -1;
        logic [15:0] last_p = 16'h0;

        always @(negedge clk) begin
            int k;
            int st;
            logic ev;
            logic eidle;
            logic [3:0] ea;
            logic [3:0] eb;
            if (!rst_n) begin
                q.delete();
                hs = -1;
                last_p = 16'h0;
                chk($sformatf("u%0d.rst.out_valid", g), int'(out_valid[g]), 0);
                chk($sformatf("u%0d.rst.busy", g), int'(busy[g]), 0);
                chk($sformatf("u%0d.rst.in_ready", g), int'(in_ready[g]), 1);
                chk($sformatf("u%0d.rst.core_a", g), int'(core_a[g]), 0);
                chk($sformatf("u%0d.rst.core_b", g), int'(core_b[g]), 0);
                chk($sformatf("u%0d.rst.out_prod", g), int'(out_prod[g]), 0);
            end else begin
                if (q.size() > 0 && hs >= 0 && cyc >= hs) begin
                    void'(q.pop_front());
                    hs = -1;
                end
                ev = 1'b0;
                eidle = 1'b1;
                ea = 4'h0;
                eb = 4'h0;
                if (q.size() > 0 && cyc >= q[0].e) begin
                    eidle = 1'b0;
                    k = cyc - q[0].e;
                    if (k >= q[0].d) begin
                        ev = 1'b1;
                        last_p = q[0].p;
                    end else begin
                        st = k / (1 + L);
                        case (st)
                            0: begin ea = q[0].a[3:0]; eb = q[0].b[3:0]; end
                            1: begin ea = q[0].a[7:4]; eb = q[0].b[3:0]; end
                            2: begin ea = q[0].a[3:0]; eb = q[0].b[7:4]; end
                            default: begin ea = q[0].a[7:4]; eb = q[0].b[7:4]; end
                        endcase
                    end
                end
                chk($sformatf("u%0d.out_valid", g), int'(out_valid[g]), int'(ev));
                chk($sformatf("u%0d.busy", g), int'(busy[g]), int'(!eidle));
                chk($sformatf("u%0d.in_ready", g), int'(in_ready[g]), int'(eidle));
                chk($sformatf("u%0d.core_a", g), int'(core_a[g]), int'(ea));
                chk($sformatf("u%0d.core_b", g), int'(core_b[g]), int'(eb));
                chk($sformatf("u%0d.out_prod", g), int'(out_prod[g]), int'(last_p));
                if (ev && out_ready && hs < 0) begin
                    hs = cyc + 1;
                end
                if (eidle && in_valid) begin
                    nj.p = 16'(in_a) * 16'(in_b);
                    nj.a = in_a;
                    nj.b = in_b;
                    nj.e = cyc + 1;
`ifdef MULT_SEQ_ZERO_SKIP_EN
                    nj.d = (in_a == 8'h00 || in_b == 8'h00) ? 0 : STEPS;
`else
                    nj.d = STEPS;
`endif
                    q.push_back(nj);
                end
            end
        end
    end

    task automatic wait_idle();
        int n;
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!(in_ready == 2'b11) && n < 200);
        if (in_ready != 2'b11) begin
            n_fail++;
            $display("FAIL wait_idle: timeout, in_ready=%b", in_ready);
        end
    endtask

    task automatic issue(input logic [7:0] a, input logic [7:0] b);
        wait_idle();
        in_valid = 1'b1;
        in_a = a;
        in_b = b;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        in_valid = 1'b0;
        in_a = 8'h00;
        in_b = 8'h00;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #3 rst_n = 1'b1;

        issue(8'hFF, 8'hFF);
        issue(8'h12, 8'h34);

        // Hold the sink off while junk operands are offered.
        wait_idle();
        out_ready = 1'b0;
        issue(8'h0A, 8'h0B);
        repeat (12) @(posedge clk);
        #1;
        in_valid = 1'b1;
        in_a = 8'h99;
        in_b = 8'h77;
        repeat (3) @(posedge clk);
        #1;
        in_valid = 1'b0;
        out_ready = 1'b1;

        issue(8'h00, 8'h5A);

        // Abort during step 2 of the combinational-core instance.
        issue(8'hC3, 8'h77);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        for (int j = 0; j < 2; j++) begin
            chk($sformatf("u%0d.async.out_valid", j), int'(out_valid[j]), 0);
            chk($sformatf("u%0d.async.busy", j), int'(busy[j]), 0);
            chk($sformatf("u%0d.async.core_a", j), int'(core_a[j]), 0);
            chk($sformatf("u%0d.async.core_b", j), int'(core_b[j]), 0);
            chk($sformatf("u%0d.async.out_prod", j), int'(out_prod[j]), 0);
        end
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;

        issue(8'h0A, 8'h0B);
        issue(8'hA5, 8'h3C);
        wait_idle();

        for (int i = 0; i < 800; i++) begin
            @(posedge clk);
            #1;
            in_valid = ($urandom_range(0, 2) != 0);
            in_a = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
            in_b = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        wait_idle();
        repeat (3) @(posedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/mult8_seq_ctrl.md
# mult8_seq_ctrl

Sequencer that computes an 8x8 unsigned product by time-sharing one 4x4 LUT/carry-chain multiplier core (the `acc_4` core) over four nibble sub-products. It accumulates the four partial results into a 16-bit product. It sits between a valid/ready operand source and a valid/ready result sink, letting the datapath reuse a single small multiplier instead of instantiating an 8x8 array.

## Interface
- `CORE_LAT`, 0 — cycles from `core_a`/`core_b` to valid `core_prod`. Legal values are 0 (combinational core) and 1 (registered core).
- `clk`  in  1  — system clock, rising edge.
- `rst_n`  in  1  — asynchronous, active-low reset.
- `in_valid`  in  1  — operand pair valid.
- `in_ready`  out  1  — block can accept operands.
- `in_a`  in  8  — multiplicand, unsigned.
- `in_b`  in  8  — multiplier, unsigned.
- `core_a`  out  4  — nibble to the shared 4x4 core `a`.
- `core_b`  out  4  — nibble to the shared 4x4 core `b`.
- `core_prod`  in  8  — 4x4 core product.
- `out_valid`  out  1  — result valid.
- `out_ready`  in  1  — sink accepts result.
- `out_prod`  out  16  — `in_a*in_b`.
- `busy`  out  1  — high in MUL or DONE.

## Operation
- FSM states:
  - IDLE: `in_ready`=1.
  - MUL: `step`=0..3, with a `lat_cnt` of 0..`CORE_LAT`.
  - DONE: `out_valid`=1.
- Accept: when `in_valid && in_ready` is high on a clock edge, latch `a_q`/`b_q`, clear `acc`, set `step`=0, and go to MUL.
- Step schedule. `core_a`/`core_b` are driven per step:
  - step 0: `a_q[3:0]`×`b_q[3:0]`, added at shift 0.
  - step 1: `a_q[7:4]`×`b_q[3:0]`, added at shift 4.
  - step 2: `a_q[3:0]`×`b_q[7:4]`, added at shift 4.
  - step 3: `a_q[7:4]`×`b_q[7:4]`, added at shift 8.
- Step hold and advance:
  - Each step holds its nibbles for 1+`CORE_LAT` cycles.
  - On the last cycle of the step, `acc <= acc + (core_prod << shift)` and `step` advances.
  - After step 3 the FSM goes to DONE.
- Accumulator width: `acc` is 16 bits. The maximum sum is 0xFE01, so there is no overflow and no carry-out is kept.
- `out_prod` is registered and loaded from the final `acc` on entry to DONE. It stays stable while `out_valid`=1.
- DONE→IDLE occurs on a clock edge with `out_ready`=1.
- `in_ready`=0 in MUL and DONE. `in_valid` in those states is ignored, and operands are not queued.
- Outside MUL, `core_a`=`core_b`=0. This gives the core no switching activity.

## Timing
- Reset (async assert, sync release):
  - FSM goes to IDLE.
  - `out_valid`=0, `out_prod`=0, `busy`=0, `core_a`=`core_b`=0.
  - `acc`, `a_q`, `b_q`, `step`, `lat_cnt` are 0.
  - `in_ready`=1 once in IDLE.
- Latency: accept at edge T gives `out_valid`=1 from cycle T+1+4·(1+`CORE_LAT`). That is T+5 for `CORE_LAT`=0 and T+9 for `CORE_LAT`=1.
- Throughput: one product per 4·(1+`CORE_LAT`)+2 cycles when `out_ready` is held high. The extra cycles are one DONE cycle and one IDLE cycle.
- `out_valid` stays high until handshake. `out_prod` does not change while `out_valid`=1.
- Reset mid-operation aborts immediately: the result is discarded and no `out_valid` is produced.
- `CORE_LAT`=1: `core_prod` is sampled on the second cycle of each step, and the nibbles remain constant across both cycles.

## Configuration
- `MULT_SEQ_ZERO_SKIP_EN` defined:
  - At accept, if `in_a`==0 or `in_b`==0, the FSM goes directly to DONE with `out_prod`=0.
  - `out_valid` is high at T+1, and the core inputs stay 0.
  - Nonzero operands are unaffected.
- Not defined: all operands take the full four-step schedule. The zero-detect logic is absent.

## Test plan
- `CORE_LAT`=0, `in_a`=0xFF, `in_b`=0xFF, accept at T -> `out_valid` at T+5, `out_prod`=0xFE01. Core inputs in order: (F,F),(F,F),(F,F),(F,F).
- `in_a`=0x12, `in_b`=0x34 -> `out_prod`=0x03A8. Core input sequence: (2,4),(1,4),(2,3),(1,3).
- Backpressure: 0x0A×0x0B with `out_ready`=0 for 3 cycles after `out_valid` -> `out_prod`=0x006E stable, `in_ready`=0, concurrent `in_valid` ignored. Release `out_ready` -> IDLE next cycle, `in_ready`=1.
- Zero operand, 0x00×0x5A:
  - With macro: `out_prod`=0x0000 at T+1, `core_a`/`core_b` stay 0.
  - Without macro: `out_prod`=0x0000 at T+5.
- Assert `rst_n`=0 during step 2 of 0xC3×0x77 -> all outputs 0 asynchronously and no `out_valid`. After release, 0x0A×0x0B -> 0x006E at T+5.
- `CORE_LAT`=1, 0xA5×0x3C -> `out_prod`=0x26AC at T+9, with each nibble pair held 2 cycles.
